// File: rtl/mem_wb_skid_pkg.sv
// Shared types and constants for the MEM/WB skid-buffered pipeline register.
// Packet layout (LSB first): lane_vld, rd_we, csr_we, rd_addr, rd_wdata, csr_waddr, csr_wdata.
package mem_wb_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Control bits sit in the low end so a flush can clear them as one slice.
    function automatic int ctrl_w(input int lanes);
        return 2 * lanes + 1;
    endfunction

    function automatic int pkt_w(input int lanes, input int xlen, input int reg_aw, input int csr_aw);
        return ctrl_w(lanes) + lanes * reg_aw + lanes * xlen + csr_aw + xlen;
    endfunction

endpackage

// File: rtl/mem_wb_skid_if.sv
// Handshake and payload bundle between the LSU stage, the MEM/WB register and write-back.
interface mem_wb_skid_if
    import mem_wb_skid_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int XLEN   = REG_BUS_W,
    parameter int REG_AW = REG_ADDR_BUS_W,
    parameter int CSR_AW = 12
);
    localparam int IW = $clog2(LANES + 1);

    logic                     valid_i;
    logic                     ready_o;
    logic [LANES-1:0]         lane_vld_i;
    logic [LANES-1:0]         rd_we_i;
    logic [LANES*REG_AW-1:0]  rd_addr_i;
    logic [LANES*XLEN-1:0]    rd_wdata_i;
    logic                     csr_we_i;
    logic [CSR_AW-1:0]        csr_waddr_i;
    logic [XLEN-1:0]          csr_wdata_i;

    logic                     valid_o;
    logic                     ready_i;
    logic [LANES-1:0]         rd_we_o;
    logic [LANES*REG_AW-1:0]  rd_addr_o;
    logic [LANES*XLEN-1:0]    rd_wdata_o;
    logic                     csr_we_o;
    logic [CSR_AW-1:0]        csr_waddr_o;
    logic [XLEN-1:0]          csr_wdata_o;
    logic [IW-1:0]            instret_incr_o;

    modport slave (
        input  valid_i, lane_vld_i, rd_we_i, rd_addr_i, rd_wdata_i,
               csr_we_i, csr_waddr_i, csr_wdata_i, ready_i,
        output ready_o, valid_o, rd_we_o, rd_addr_o, rd_wdata_o,
               csr_we_o, csr_waddr_o, csr_wdata_o, instret_incr_o
    );

    modport master (
        output valid_i, lane_vld_i, rd_we_i, rd_addr_i, rd_wdata_i,
               csr_we_i, csr_waddr_i, csr_wdata_i, ready_i,
        input  ready_o, valid_o, rd_we_o, rd_addr_o, rd_wdata_o,
               csr_we_o, csr_waddr_o, csr_wdata_o, instret_incr_o
    );

endinterface

// File: rtl/mem_wb_skid_wb_pkt_reg.sv
// Packet register with load enable; clr drops only the low control slice, rst zeroes everything.
module wb_pkt_reg
    import mem_wb_skid_pkg::*;
#(
    parameter int W      = 8,
    parameter int CTRL_W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q[CTRL_W-1:0] <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a 2-entry skid buffer and per-transfer instret count.
// Optional MEM_WB_STALL_CNT_EN adds stall_cnt_o, a saturating count of stalled output cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing buffered, valid_o low
//   ST_ONE   | main register holds the oldest packet
//   ST_FULL  | main and skid both hold packets, ready_o low
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int XLEN   = REG_BUS_W,
    parameter int REG_AW = REG_ADDR_BUS_W,
    parameter int CSR_AW = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
`ifdef MEM_WB_STALL_CNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    mem_wb_skid_if.slave bus
);

    localparam int CW = ctrl_w(LANES);
    localparam int PW = pkt_w(LANES, XLEN, REG_AW, CSR_AW);
    localparam int IW = $clog2(LANES + 1);
    localparam int AO = CW;
    localparam int DO = AO + LANES * REG_AW;
    localparam int CAO = DO + LANES * XLEN;
    localparam int CDO = CAO + CSR_AW;

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             main_ld;
    logic             skid_ld;
    logic             main_from_skid;
    logic             in_fire;
    logic             out_fire;
    logic             valid;
    logic             ready;
    logic [LANES-1:0] we_cap;
    logic [PW-1:0]    in_pkt;
    logic [PW-1:0]    main_d;
    logic [PW-1:0]    main_q;
    logic [PW-1:0]    skid_q;
    logic [IW-1:0]    pop;

    // The younger lane owns a shared rd, so the older write is suppressed at capture.
    if (LANES == 2) begin : g_hazard
        always_comb begin
            we_cap = bus.rd_we_i;
            if (bus.rd_we_i[0] && bus.rd_we_i[1] &&
                bus.rd_addr_i[REG_AW-1:0] == bus.rd_addr_i[2*REG_AW-1:REG_AW]) begin
                we_cap[0] = WRITE_DISABLE;
            end
        end
    end else begin : g_no_hazard
        assign we_cap = bus.rd_we_i;
    end

    assign in_pkt = {bus.csr_wdata_i, bus.csr_waddr_i, bus.rd_wdata_i, bus.rd_addr_i,
                     bus.csr_we_i, we_cap, bus.lane_vld_i};
    assign main_d = main_from_skid ? skid_q : in_pkt;

    assign ready    = (state_q != ST_FULL);
    assign valid    = (state_q != ST_EMPTY);
    assign in_fire  = bus.valid_i & ready;
    assign out_fire = valid & bus.ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    wb_pkt_reg #(.W(PW), .CTRL_W(CW)) u_main (
        .clk (clk_i),
        .rst (rst_i),
        .clr (flush_i),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    wb_pkt_reg #(.W(PW), .CTRL_W(CW)) u_skid (
        .clk (clk_i),
        .rst (rst_i),
        .clr (flush_i),
        .ld  (skid_ld),
        .d   (in_pkt),
        .q   (skid_q)
    );

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + IW'(main_q[i]);
        end
    end

    assign bus.ready_o        = ready;
    assign bus.valid_o        = valid;
    assign bus.rd_we_o        = out_fire ? main_q[2*LANES-1:LANES] : '0;
    assign bus.csr_we_o       = out_fire ? main_q[2*LANES] : WRITE_DISABLE;
    assign bus.instret_incr_o = out_fire ? pop : '0;
    assign bus.rd_addr_o      = main_q[AO +: LANES*REG_AW];
    assign bus.rd_wdata_o     = main_q[DO +: LANES*XLEN];
    assign bus.csr_waddr_o    = main_q[CAO +: CSR_AW];
    assign bus.csr_wdata_o    = main_q[CDO +: XLEN];

`ifdef MEM_WB_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (valid && !bus.ready_i && stall_cnt_o != 32'hFFFF_FFFF) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised next-generation MEM/WB pipeline register for multi-issue cores.
- Carries LANES GPR write-back lanes plus one CSR write (lane 0 only) from the LSU stage to write-back.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not drop data.
- Reports retired-instruction count per transfer.

Parameters:
- LANES, 2, number of GPR write-back lanes (1 or 2).
- XLEN, 32, GPR/CSR data width.
- REG_AW, 5, GPR address width.
- CSR_AW, 12, CSR address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all buffered entries.
- valid_i  in  1  upstream packet valid.
- ready_o  out  1  stage can accept a packet.
- lane_vld_i  in  LANES  per-lane instruction present (counts toward instret).
- rd_we_i  in  LANES  per-lane GPR write enable.
- rd_addr_i  in  LANES*REG_AW  per-lane rd address, lane 0 in LSBs.
- rd_wdata_i  in  LANES*XLEN  per-lane rd data.
- csr_we_i  in  1  CSR write enable.
- csr_waddr_i  in  CSR_AW  CSR address.
- csr_wdata_i  in  XLEN  CSR data.
- valid_o  out  1  write-back packet valid.
- ready_i  in  1  write-back can consume.
- rd_we_o  out  LANES  gated GPR write enables.
- rd_addr_o  out  LANES*REG_AW  rd addresses.
- rd_wdata_o  out  LANES*XLEN  rd data.
- csr_we_o  out  1  gated CSR write enable.
- csr_waddr_o  out  CSR_AW  CSR address.
- csr_wdata_o  out  XLEN  CSR data.
- instret_incr_o  out  $clog2(LANES+1)  instructions retired this cycle.

Behaviour:
- Handshake:
  - Input fire = valid_i & ready_o.
  - Output fire = valid_o & ready_i.
  - Packet order is preserved; no packet is dropped or duplicated.
- Storage: main register (drives outputs) plus one skid register.
- State machine, 2 bits:
  - EMPTY: in fire -> ONE.
  - ONE:
    - in fire & !out fire -> FULL (packet into skid).
    - out fire & !in fire -> EMPTY.
    - both -> ONE (new packet into main).
  - FULL:
    - out fire -> ONE (skid moves to main).
    - else hold.
- ready_o is registered and equals (state != FULL). Its only combinational dependence is state, not ready_i.
- valid_o = (state != EMPTY).
- Latency: 1 cycle from input fire to valid_o when EMPTY.
- Output gating:
  - rd_we_o, csr_we_o and instret_incr_o are forced to 0 unless valid_o & ready_i.
  - Data/address outputs always reflect the main register.
- instret_incr_o = popcount of the main register's lane_vld on output fire, else 0.
- Same-rd hazard, resolved at capture:
  - If LANES==2, both rd_we set and rd_addr equal, lane 0's we is cleared; lane 1 (younger) wins.
  - Writes to x0 pass through; the regfile ignores them.
- flush_i:
  - Next state EMPTY, all stored we/lane_vld cleared, ready_o=1 next cycle.
  - Flush has priority over simultaneous in/out fire; a concurrent input packet is discarded.
- rst_i: same as flush, plus all stored data/address fields are set to 0. Reset mid-FULL loses both entries.
- Outputs after reset: valid_o=0, ready_o=1, all we=0, instret_incr_o=0, data/address=0.

Optional Feature:
- MEM_WB_STALL_CNT_EN
- When defined:
  - Adds output stall_cnt_o (32 bits).
  - Counts cycles with valid_o & !ready_i, saturating at 0xFFFFFFFF.
  - Cleared by rst_i only, not by flush_i.
- When undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package/defines holds:
  - Skid state encodings (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2).
  - Existing RegBus/RegAddrBus widths.
  - WriteEnable/WriteDisable constants.
  - Packet field widths derived from parameters.
- One sub-module: wb_pkt_reg. It is a parametrised packet register with load enable and synchronous clear, instantiated twice (main, skid).

Test Plan:
- Reset then pass-through:
  - Stimulus: rst_i 1 cycle, then valid_i=1, ready_i=1; lane0 rd=5, data 0x1234, we=1; lane1 lane_vld=0.
  - Response: next cycle valid_o=1, rd_we_o=2'b01, rd_wdata lane0=0x1234, instret_incr_o=1.
- Back-pressure:
  - Stimulus: ready_i=0, three packets A, B, C offered.
  - Response: A and B accepted; ready_o=0 after B; C held upstream.
  - Stimulus: then ready_i=1.
  - Response: outputs A, B, C in order on consecutive cycles, no loss.
- Same-rd collision:
  - Stimulus: both lanes we=1, rd=7, data 0xAAAA / 0xBBBB.
  - Response: rd_we_o=2'b10, only 0xBBBB written, instret_incr_o=2.
- Flush in FULL:
  - Stimulus: fill two entries, assert flush_i with valid_i=1.
  - Response: next cycle valid_o=0, ready_o=1, incoming packet dropped, no writes.
- CSR path:
  - Stimulus: csr_we_i=1, addr 0x300, data 0x8, with ready_i=0 for 2 cycles.
  - Response: csr_we_o=0 while stalled; csr_we_o=1 with 0x300/0x8 exactly once when ready_i=1.
- Stall counter (MEM_WB_STALL_CNT_EN):
  - Stimulus: hold valid_o=1, ready_i=0 for 10 cycles.
  - Response: stall_cnt_o=10; value unchanged by flush_i; 0 after rst_i.
